// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the branch target buffer.
// Counter encoding is the usual 2-bit saturating scheme; MSB set means predict taken.
package core101_bp_pkg;

  localparam int BP_XLEN    = 32;
  localparam int BP_ENTRIES = 16;
  localparam int BP_IDXW    = $clog2(BP_ENTRIES);
  localparam int BP_TAGW    = BP_XLEN - BP_IDXW - 2;

  localparam logic [1:0] CTR_SNT   = 2'b00;
  localparam logic [1:0] CTR_WNT   = 2'b01;
  localparam logic [1:0] CTR_WT    = 2'b10;
  localparam logic [1:0] CTR_ST    = 2'b11;
  localparam logic [1:0] CTR_RESET = CTR_WNT;
  localparam logic [1:0] CTR_ALLOC = CTR_WT;

  // Entry layout for the default geometry; the top re-derives it from its own parameters.
  typedef struct packed {
    logic               valid;
    logic [BP_TAGW-1:0] tag;
    logic [BP_XLEN-1:0] target;
    logic [1:0]         ctr;
  } btb_entry_t;

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// 2-bit saturating direction counter next-state function.
module bp_sat_counter
  import core101_bp_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters; combinational lookup, trained by execute.
// Optional BP_STATS_EN adds free-running update/allocation counters.
module branch_predictor
  import core101_bp_pkg::*;
#(
  parameter int XLEN    = BP_XLEN,
  parameter int ENTRIES = BP_ENTRIES
) (
  input  logic            clock_in,
  input  logic            reset_in,
  input  logic [XLEN-1:0] bp_pc_in,
  output logic            bp_pred_en_out,
  output logic [XLEN-1:0] bp_pred_addr_out,
  input  logic            bp_upd_valid_in,
  input  logic [XLEN-1:0] bp_upd_pc_in,
  input  logic [XLEN-1:0] bp_upd_target_in,
  input  logic            bp_upd_taken_in,
`ifdef BP_STATS_EN
  output logic [31:0]     bp_stat_alloc_out,
  output logic [31:0]     bp_stat_upd_out,
`endif
  input  logic            bp_flush_in
);

  localparam int IDXW = $clog2(ENTRIES);
  localparam int TAGW = XLEN - IDXW - 2;

  typedef struct packed {
    logic            valid;
    logic [TAGW-1:0] tag;
    logic [XLEN-1:0] target;
    logic [1:0]      ctr;
  } entry_t;

  entry_t tbl_q [ENTRIES];
  entry_t tbl_d [ENTRIES];

  // Lookup path
  logic [IDXW-1:0] l_idx;
  logic [TAGW-1:0] l_tag;
  entry_t          l_ent;
  logic            l_hit;

  assign l_idx = bp_pc_in[IDXW+1:2];
  assign l_tag = bp_pc_in[XLEN-1:IDXW+2];
  assign l_ent = tbl_q[l_idx];
  assign l_hit = l_ent.valid && (l_ent.tag == l_tag);

  assign bp_pred_en_out   = l_hit && l_ent.ctr[1];
  assign bp_pred_addr_out = bp_pred_en_out ? l_ent.target : '0;

  // Update path
  logic [IDXW-1:0] u_idx;
  logic [TAGW-1:0] u_tag;
  entry_t          u_ent;
  logic            u_hit;
  logic            u_acc;
  logic            u_alloc;
  logic [1:0]      u_ctr_next;

  assign u_idx   = bp_upd_pc_in[IDXW+1:2];
  assign u_tag   = bp_upd_pc_in[XLEN-1:IDXW+2];
  assign u_ent   = tbl_q[u_idx];
  assign u_hit   = u_ent.valid && (u_ent.tag == u_tag);
  assign u_acc   = bp_upd_valid_in && !bp_flush_in;
  assign u_alloc = u_acc && !u_hit && bp_upd_taken_in;

  bp_sat_counter u_ctr (
    .ctr      (u_ent.ctr),
    .taken    (bp_upd_taken_in),
    .ctr_next (u_ctr_next)
  );

  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{bp_pc_in[1:0], bp_upd_pc_in[1:0]};

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) tbl_d[i] = tbl_q[i];
    if (bp_flush_in) begin
      // Flush only drops valid bits; stale tag/target/ctr are harmless.
      for (int i = 0; i < ENTRIES; i++) tbl_d[i].valid = 1'b0;
    end else if (u_acc) begin
      if (u_hit) begin
        tbl_d[u_idx].ctr = u_ctr_next;
        if (bp_upd_taken_in) tbl_d[u_idx].target = bp_upd_target_in;
      end else if (bp_upd_taken_in) begin
        tbl_d[u_idx].valid  = 1'b1;
        tbl_d[u_idx].tag    = u_tag;
        tbl_d[u_idx].target = bp_upd_target_in;
        tbl_d[u_idx].ctr    = CTR_ALLOC;
      end
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_q[i].valid  <= 1'b0;
        tbl_q[i].tag    <= '0;
        tbl_q[i].target <= '0;
        tbl_q[i].ctr    <= CTR_RESET;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= tbl_d[i];
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] stat_alloc_q, stat_alloc_d;
  logic [31:0] stat_upd_q, stat_upd_d;

  assign stat_upd_d   = u_acc   ? stat_upd_q + 32'd1   : stat_upd_q;
  assign stat_alloc_d = u_alloc ? stat_alloc_q + 32'd1 : stat_alloc_q;

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      stat_upd_q   <= '0;
      stat_alloc_q <= '0;
    end else begin
      stat_upd_q   <= stat_upd_d;
      stat_alloc_q <= stat_alloc_d;
    end
  end

  assign bp_stat_upd_out   = stat_upd_q;
  assign bp_stat_alloc_out = stat_alloc_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (default ENTRIES=16, XLEN=32).
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        en;
  logic [31:0] addr;
  logic        upd_v;
  logic [31:0] upd_pc;
  logic [31:0] upd_tgt;
  logic        upd_tk;
  logic        flush;
`ifdef BP_STATS_EN
  logic [31:0] st_alloc;
  logic [31:0] st_upd;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  branch_predictor #(.XLEN(32), .ENTRIES(16)) dut (
    .clock_in         (clk),
    .reset_in         (rst),
    .bp_pc_in         (pc),
    .bp_pred_en_out   (en),
    .bp_pred_addr_out (addr),
    .bp_upd_valid_in  (upd_v),
    .bp_upd_pc_in     (upd_pc),
    .bp_upd_target_in (upd_tgt),
    .bp_upd_taken_in  (upd_tk),
`ifdef BP_STATS_EN
    .bp_stat_alloc_out(st_alloc),
    .bp_stat_upd_out  (st_upd),
`endif
    .bp_flush_in      (flush)
  );

  // Drive one update across one rising edge; returns 1ns after the edge.
  task automatic upd(input logic [31:0] p, input logic [31:0] t, input logic tk);
    upd_pc = p; upd_tgt = t; upd_tk = tk; upd_v = 1'b1;
    @(posedge clk); #1;
    upd_v = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    pc = 32'h100; #1;
    n_checks++;
    if (en !== 1'b0) begin n_fail++; $display("FAIL reset_en got=%0b exp=0", en); end
    n_checks++;
    if (addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", addr); end
  endtask

  task automatic test_alloc();
    upd(32'h100, 32'h200, 1'b1);
    pc = 32'h100; #1;
    n_checks++;
    if (en !== 1'b1 || addr !== 32'h200) begin
      n_fail++; $display("FAIL alloc_hit got=%0b/%h exp=1/00000200", en, addr);
    end
    pc = 32'h140; #1;
    n_checks++;
    if (en !== 1'b0 || addr !== 32'h0) begin
      n_fail++; $display("FAIL alloc_tag_miss got=%0b/%h exp=0/00000000", en, addr);
    end
    // Not-taken miss must not allocate.
    upd(32'h108, 32'h900, 1'b0);
    upd(32'h108, 32'h900, 1'b1);
    upd(32'h108, 32'h900, 1'b0);
    pc = 32'h108; #1;
    n_checks++;
    if (en !== 1'b0) begin n_fail++; $display("FAIL nt_miss_no_alloc got=%0b exp=0", en); end
  endtask

  task automatic test_saturation();
    pc = 32'h100;
    upd(32'h100, 32'hBAD, 1'b0); #1;   // 10 -> 01
    n_checks++;
    if (en !== 1'b0 || addr !== 32'h0) begin
      n_fail++; $display("FAIL sat_nt1 got=%0b/%h exp=0/00000000", en, addr);
    end
    upd(32'h100, 32'hBAD, 1'b0);       // 01 -> 00
    upd(32'h100, 32'hBAD, 1'b0); #1;   // 00 stays
    n_checks++;
    if (en !== 1'b0) begin n_fail++; $display("FAIL sat_nt3 got=%0b exp=0", en); end
    upd(32'h100, 32'h200, 1'b1); #1;   // 00 -> 01
    n_checks++;
    if (en !== 1'b0) begin n_fail++; $display("FAIL sat_t1 got=%0b exp=0", en); end
    upd(32'h100, 32'h200, 1'b1); #1;   // 01 -> 10
    n_checks++;
    if (en !== 1'b1 || addr !== 32'h200) begin
      n_fail++; $display("FAIL sat_t2 got=%0b/%h exp=1/00000200", en, addr);
    end
    upd(32'h100, 32'h280, 1'b1);       // 10 -> 11, target replaced
    upd(32'h100, 32'h280, 1'b1); #1;   // 11 stays
    n_checks++;
    if (en !== 1'b1 || addr !== 32'h280) begin
      n_fail++; $display("FAIL sat_top got=%0b/%h exp=1/00000280", en, addr);
    end
    upd(32'h100, 32'hBAD, 1'b0); #1;   // 11 -> 10, target kept
    n_checks++;
    if (en !== 1'b1 || addr !== 32'h280) begin
      n_fail++; $display("FAIL sat_top_nt got=%0b/%h exp=1/00000280", en, addr);
    end
  endtask

  task automatic test_same_cycle();
    pc = 32'h300;
    upd_pc = 32'h300; upd_tgt = 32'h500; upd_tk = 1'b1; upd_v = 1'b1;
    @(negedge clk);
    n_checks++;
    if (en !== 1'b0) begin n_fail++; $display("FAIL same_cycle_pre got=%0b exp=0", en); end
    @(posedge clk); #1;
    upd_v = 1'b0; #1;
    n_checks++;
    if (en !== 1'b1 || addr !== 32'h500) begin
      n_fail++; $display("FAIL same_cycle_post got=%0b/%h exp=1/00000500", en, addr);
    end
    pc = 32'h100; #1;   // replaced by 0x300 at index 0
    n_checks++;
    if (en !== 1'b0) begin n_fail++; $display("FAIL replaced_old got=%0b exp=0", en); end
  endtask

  task automatic test_flush();
    upd(32'h104, 32'h600, 1'b1);
    pc = 32'h104; #1;
    n_checks++;
    if (en !== 1'b1 || addr !== 32'h600) begin
      n_fail++; $display("FAIL pre_flush got=%0b/%h exp=1/00000600", en, addr);
    end
    flush = 1'b1;
    upd(32'h400, 32'h700, 1'b1);
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: pc = 32'h104;
        1: pc = 32'h300;
        2: pc = 32'h400;
        default: pc = 32'h100;
      endcase
      #1;
      n_checks++;
      if (en !== 1'b0 || addr !== 32'h0) begin
        n_fail++; $display("FAIL flush_pc%h got=%0b/%h exp=0/00000000", pc, en, addr);
      end
    end
    upd(32'h104, 32'h610, 1'b1);
    pc = 32'h104; #1;
    n_checks++;
    if (en !== 1'b1 || addr !== 32'h610) begin
      n_fail++; $display("FAIL post_flush_alloc got=%0b/%h exp=1/00000610", en, addr);
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    upd(32'h104, 32'h620, 1'b1);
    rst = 1'b0;
    pc = 32'h104; #1;
    n_checks++;
    if (en !== 1'b0 || addr !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid got=%0b/%h exp=0/00000000", en, addr);
    end
  endtask

`ifdef BP_STATS_EN
  task automatic test_stats();
    do_reset();
    upd(32'h100, 32'h10, 1'b1);
    upd(32'h104, 32'h20, 1'b1);
    upd(32'h108, 32'h30, 1'b1);
    upd(32'h10C, 32'h40, 1'b0);
    n_checks++;
    if (st_upd !== 32'd4 || st_alloc !== 32'd3) begin
      n_fail++; $display("FAIL stats_count got=%0d/%0d exp=4/3", st_upd, st_alloc);
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_checks++;
    if (st_upd !== 32'd4 || st_alloc !== 32'd3) begin
      n_fail++; $display("FAIL stats_flush got=%0d/%0d exp=4/3", st_upd, st_alloc);
    end
    do_reset();
    n_checks++;
    if (st_upd !== 32'd0 || st_alloc !== 32'd0) begin
      n_fail++; $display("FAIL stats_reset got=%0d/%0d exp=0/0", st_upd, st_alloc);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; pc = '0; upd_v = 1'b0; upd_pc = '0; upd_tgt = '0; upd_tk = 1'b0; flush = 1'b0;
    test_reset();
    test_alloc();
    test_saturation();
    test_same_cycle();
    test_flush();
    test_reset_mid();
`ifdef BP_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
